regfile_wb_arb: RTL
===================

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, consecutive lost contests before execute wins once.
REQ-002 SHALL have parameter CNT_W, default 16, width of conflict counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports ex_valid in 1, ex_ready out 1, ex_pc in 64, ex_rd in 5, ex_data in 64: execute writeback request.
REQ-006 SHALL have ports ld_valid in 1, ld_ready out 1, ld_pc in 64, ld_rd in 5, ld_data in 64: load-unit writeback request.
REQ-007 SHALL have ports wr_en out 1, wr_rd out 5, wr_data out 64, wr_pc out 64: single regfile write port, also feeds the debug register monitor.
REQ-008 SHALL have port conflict_cnt  output  CNT_W  saturating count of contested cycles.

Function
REQ-009 SHALL grant at most one requester per cycle; ready combinational from valids and state; transfer = valid & ready same cycle.
REQ-010 SHALL never assert a ready whose valid is low; requesters hold valid and payload stable until ready.
REQ-011 SHALL grant sole valid requester unconditionally.
REQ-012 SHALL, both valid, grant load unless starve_cnt == STARVE_LIMIT, then grant execute.
REQ-013 SHALL increment starve_cnt when both valid and load granted; clear it when execute granted or ex_valid low.
REQ-014 SHALL register the granted payload: transfer in cycle N -> wr_rd/wr_data/wr_pc show it in N+1.
REQ-015 SHALL assert wr_en in N+1 only if transfer in N and captured rd != 0; rd == 0 still consumes handshake, wr_en = 0, fields update.
REQ-016 SHALL, with no transfer in N, drive wr_en = 0 in N+1 and hold wr_rd/wr_data/wr_pc.
REQ-017 SHALL increment conflict_cnt every cycle ex_valid & ld_valid; hold at all-ones (no wrap).
REQ-018 SHALL keep ordering by grant; no reordering of same-requester transfers; same-rd from both in one cycle: load written first, execute next grant.
REQ-019 SHALL have latency exactly 1 cycle request-to-write; no internal buffering beyond output register; throughput 1 write/cycle.

Reset
REQ-020 SHALL, on clk edge with rst_n low: wr_en 0, wr_rd 0, wr_data 0, wr_pc 0, starve_cnt 0, conflict_cnt 0.
REQ-021 SHALL force ex_ready = ld_ready = 0 while rst_n low; no transfer occurs in that cycle.
REQ-022 SHALL, after rst_n rises, resume arbitration next cycle with load priority.

Verification
REQ-023 ex only: ex_valid=1, pc 0x1004, rd 7, data 8 -> ex_ready=1 same cycle; next cycle wr_en=1, wr_rd 7, wr_data 8, wr_pc 0x1004.
REQ-024 both valid 4 cycles, new ld payload each cycle, ex held -> grants ld,ld,ld,ex; starve_cnt 1,2,3,0; conflict_cnt 4.
REQ-025 ld only rd 0, data 0x55 -> ld_ready=1; next cycle wr_en=0, wr_rd 0, wr_data 0x55.
REQ-026 write then idle -> wr_en 1 then 0; wr_rd/wr_data/wr_pc hold previous values.
REQ-027 rst_n low 1 cycle with both valid mid-stream, starve_cnt 2 -> readys 0 that cycle; next cycle all outputs 0, starve_cnt 0; then ld granted first.
REQ-028 CNT_W=4, 20 consecutive both-valid cycles -> conflict_cnt reaches 15 and holds 15.

Source files
------------

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb
//   Arbitrates two writeback requesters (execute, load unit) onto the single
//   register-file write port. Load normally wins a contest; execute wins once
//   after losing STARVE_LIMIT consecutive contests. The granted payload is
//   registered, so it appears on the write port one cycle after the handshake.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   ex_valid/ex_ready/ex_pc/ex_rd/ex_data   execute writeback request
//   ld_valid/ld_ready/ld_pc/ld_rd/ld_data   load-unit writeback request
//   wr_en/wr_rd/wr_data/wr_pc       registered regfile write port (also debug monitor)
//   conflict_cnt                    saturating count of cycles with both valid

module regfile_wb_arb #(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [63:0]      ex_pc,
    input  logic [4:0]       ex_rd,
    input  logic [63:0]      ex_data,

    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [63:0]      ld_pc,
    input  logic [4:0]       ld_rd,
    input  logic [63:0]      ld_data,

    output logic             wr_en,
    output logic [4:0]       wr_rd,
    output logic [63:0]      wr_data,
    output logic [63:0]      wr_pc,

    output logic [CNT_W-1:0] conflict_cnt
);

    // Counter must hold values 0..STARVE_LIMIT.
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic          contest;
    logic          ex_turn;
    logic          grant_ex;
    logic          grant_ld;

    assign contest = ex_valid & ld_valid;
    assign ex_turn = (starve_cnt == SW'(STARVE_LIMIT));

    // Readys are gated by rst_n so nothing transfers during a reset cycle.
    always_comb begin
        grant_ex = 1'b0;
        grant_ld = 1'b0;
        if (rst_n) begin
            if (contest) begin
                grant_ex = ex_turn;
                grant_ld = ~ex_turn;
            end else begin
                grant_ex = ex_valid;
                grant_ld = ld_valid;
            end
        end
    end

    assign ex_ready = grant_ex;
    assign ld_ready = grant_ld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt   <= '0;
            conflict_cnt <= '0;
            wr_en        <= 1'b0;
            wr_rd        <= '0;
            wr_data      <= '0;
            wr_pc        <= '0;
        end else begin
            // Streak counts only contests that execute lost.
            if (contest && grant_ld)
                starve_cnt <= starve_cnt + SW'(1);
            else
                starve_cnt <= '0;

            if (contest && (conflict_cnt != {CNT_W{1'b1}}))
                conflict_cnt <= conflict_cnt + CNT_W'(1);

            // rd 0 still completes the handshake and updates the fields,
            // but never raises the write enable.
            if (grant_ld) begin
                wr_en   <= (ld_rd != 5'd0);
                wr_rd   <= ld_rd;
                wr_data <= ld_data;
                wr_pc   <= ld_pc;
            end else if (grant_ex) begin
                wr_en   <= (ex_rd != 5'd0);
                wr_rd   <= ex_rd;
                wr_data <= ex_data;
                wr_pc   <= ex_pc;
            end else begin
                wr_en   <= 1'b0;
            end
        end
    end

endmodule
